// File: rtl/servo_pkg.sv
// servo_pkg: default servo timing constants and the frame counter type
package servo_pkg;
  localparam int CLK_HZ = 25_000_000;
  localparam int PERIOD_CYC = 500_000;
  localparam int MIN_CYC = 25_000;
  localparam int MAX_CYC = 50_000;
  localparam int CNT_W = $clog2(PERIOD_CYC);
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: frame counter, frame-boundary width latch and registered pwm output
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC = servo_pkg::PERIOD_CYC,
  parameter int MIN_CYC = servo_pkg::MIN_CYC,
  parameter int W = $clog2(PERIOD_CYC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] width,
  output logic         pwm
);
  logic [W-1:0] cnt;
  logic [W-1:0] frame_width;
  logic         last;
  assign last = cnt == W'(PERIOD_CYC - 1);
  // free-running frame counter, wraps straight back to 0
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= last ? '0 : cnt + 1'b1;
  // pulse width is only taken at the frame boundary so a pulse is never cut or stretched
  always_ff @(posedge clk or posedge rst)
    if (rst) frame_width <= W'(MIN_CYC);
    else if (last) frame_width <= width;
  // high for the first frame_width counts of every frame
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm <= 1'b0;
    else pwm <= cnt < frame_width;
endmodule

// File: rtl/servo_pwm_top.sv
// servo_pwm_top: switch-selected two-position 50 Hz hobby-servo pwm generator
module servo_pwm_top
  import servo_pkg::*;
#(
  parameter int CLK_HZ = servo_pkg::CLK_HZ,
  parameter int PERIOD_CYC = servo_pkg::PERIOD_CYC,
  parameter int MIN_CYC = servo_pkg::MIN_CYC,
  parameter int MAX_CYC = servo_pkg::MAX_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic salida
);
  localparam int W = $clog2(PERIOD_CYC);
  if (!(CLK_HZ > 0 && MIN_CYC > 0 && MIN_CYC <= MAX_CYC && MAX_CYC < PERIOD_CYC)) begin : g_bad_params
    $fatal(1, "servo_pwm_top: need 0 < MIN_CYC <= MAX_CYC < PERIOD_CYC");
  end
  logic         sw_m;
  logic         sw_s;
  logic [W-1:0] width;
  // two-flop synchronizer for the asynchronous switch
  always_ff @(posedge clk or posedge rst)
    if (rst) {sw_s, sw_m} <= 2'b00;
    else {sw_s, sw_m} <= {sw_m, sw};
  assign width = sw_s ? W'(MAX_CYC) : W'(MIN_CYC);
  servo_pwm_gen #(
    .PERIOD_CYC(PERIOD_CYC),
    .MIN_CYC(MIN_CYC),
    .W(W)
  ) u_gen (
    .clk(clk),
    .rst(rst),
    .width(width),
    .pwm(salida)
  );
endmodule

// File: tb/tb_servo_pwm_top.sv
// tb_servo_pwm_top: scoreboard bench measuring pulse widths and frame periods on a scaled-down servo
module tb_servo_pwm_top;
  localparam int P = 200;
  localparam int MN = 10;
  localparam int MX = 30;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw = 1'b0;
  logic salida;
  int cyc = 0;
  int e0 = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  logic prev = 1'b0;
  logic have_rise = 1'b0;
  int rise_at = 0;

  servo_pwm_top #(.CLK_HZ(25_000_000), .PERIOD_CYC(P), .MIN_CYC(MN), .MAX_CYC(MX)) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .salida(salida)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // pulse monitor: width of each pulse against the scoreboard, spacing between rising edges
  always @(negedge clk) begin
    if (rst) begin
      prev = 1'b0;
      have_rise = 1'b0;
    end else begin
      if (salida && !prev) begin
        if (have_rise) chk("period", cyc - rise_at, P);
        have_rise = 1'b1;
        rise_at = cyc;
      end
      if (!salida && prev) begin
        if (exp_q.size() == 0) chk("extra_pulse_width", cyc - rise_at, 0);
        else chk("pulse_width", cyc - rise_at, exp_q.pop_front());
      end
      prev = salida;
    end
  end

  task automatic start(input logic s);
    rst = 1'b1;
    sw = s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e0 = cyc + 1;
  endtask

  task automatic at(input int k);
    while (cyc < e0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    chk("queue_drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("reset_hold", salida, 0);
    end
    rst = 1'b0;
    e0 = cyc + 1;
    repeat (6) exp_q.push_back(MN);
    at(0);
    chk("first_edge_high", salida, 1);
    at(5 * P + MX + 2);
    drain();

    start(1'b1);
    exp_q.push_back(MN);
    repeat (3) exp_q.push_back(MX);
    at(3 * P + MX + 2);
    drain();

    start(1'b0);
    exp_q.push_back(MN);
    exp_q.push_back(MX);
    exp_q.push_back(MN);
    exp_q.push_back(MN);
    at(50);
    sw = 1'b1;
    at(P + 90);
    sw = 1'b0;
    at(3 * P + MX + 2);
    drain();

    start(1'b0);
    exp_q.push_back(MN);
    exp_q.push_back(MN);
    exp_q.push_back(MX);
    exp_q.push_back(MN);
    at(P - 2);
    sw = 1'b1;
    at(3 * P - 4);
    sw = 1'b0;
    at(3 * P + MX + 2);
    drain();

    start(1'b0);
    exp_q.push_back(MN);
    at(P + MN / 2);
    chk("pre_reset_high", salida, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_drop", salida, 0);
    drain();
    sw = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_low", salida, 0);
    rst = 1'b0;
    e0 = cyc + 1;
    exp_q.push_back(MN);
    exp_q.push_back(MX);
    at(0);
    chk("restart_high", salida, 1);
    at(P + MX + 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_pwm_top.md
# servo_pwm_top

Hobby-servo PWM generator: turns a single switch into a fixed-frame 50 Hz pulse train whose high time selects one of two servo positions. It is the top level of the servo demo: `sw` comes from a board switch and `salida` drives the servo signal pin. All logic runs on one clock with an asynchronous active-high reset.

## Interface
- `CLK_HZ`, default 25_000_000: input clock frequency in Hz (40 ns period).
- `PERIOD_CYC`, default 500_000: frame length in clocks (20 ms at 25 MHz).
- `MIN_CYC`, default 25_000: pulse high time in clocks when `sw`=0 (1 ms).
- `MAX_CYC`, default 50_000: pulse high time in clocks when `sw`=1 (2 ms).
- `clk` input 1: system clock; all registers are rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `sw` input 1: position select, asynchronous to `clk`; 0 selects MIN_CYC, 1 selects MAX_CYC.
- `salida` output 1: registered PWM servo signal.

## Operation
- Synchronizer: `sw` passes through two flip-flops (reset 0) to give `sw_s`.
- Frame counter `cnt`:
  - Width is ceil(log2(PERIOD_CYC)), 19 bits at the defaults.
  - Counts 0..PERIOD_CYC-1 and increments every clock.
  - Wraps from PERIOD_CYC-1 to 0 with no idle cycle.
- Width register `width`:
  - Loaded only when `cnt`==PERIOD_CYC-1, with `sw_s` ? MAX_CYC : MIN_CYC.
  - Holds its value for the whole frame, so a pulse is never truncated or stretched mid-frame.
- Output: `salida` <= (`cnt` < `width`). The comparison is unsigned and at full counter width.
- Reset values:
  - `cnt`=0, `width`=MIN_CYC, `salida`=0, synchronizer flops 0.
  - Reset takes effect immediately, including mid-pulse: `salida` drops asynchronously.
- Legality: 0 < MIN_CYC ≤ MAX_CYC < PERIOD_CYC. Check this at elaboration and fail the build on violation.

## Timing
- After `rst` falls, the first rising edge samples `cnt`=0 and sets `salida`=1.
- `salida` stays high for exactly `width` clocks, then low for PERIOD_CYC-`width` clocks.
- Frame period is exactly PERIOD_CYC clocks: 20.000 ms at defaults.
- With `sw`=0 from reset at defaults, `salida` is high over [0,1) ms, [20,21) ms, [40,41) ms, and so on. Each interval is offset by the one-clock output register.
- `sw` latency:
  - A change must be present in `sw_s` (2 clocks after the `sw` edge) by the edge where `cnt`=PERIOD_CYC-1.
  - It then applies to the next frame's pulse.
  - Otherwise it applies one frame later.
  - It never applies to the current frame.
- A `sw` change coinciding with the load cycle follows the synchronizer value sampled at that edge.
- Reset asserted mid-frame: on release, a fresh frame starts from `cnt`=0 with `width`=MIN_CYC, whatever the value of `sw`.

## Structure
- Shared package `servo_pkg` holds:
  - the default constants: CLK_HZ, PERIOD_CYC, MIN_CYC, MAX_CYC;
  - a `cnt_t` width localparam derived with $clog2.
- One sub-module `servo_pwm_gen` (clk, rst, width in, pwm out) contains the counter, the frame-boundary width latch and the output register.
- `servo_pwm_top` contains the synchronizer and the MIN/MAX mux, and instantiates `servo_pwm_gen`.

## Test plan
- Reset: hold `rst`=1 for 5 clocks with `sw`=0 -> `salida`=0 throughout. On release, `salida` rises on the first edge and stays high exactly 25_000 clocks.
- Steady `sw`=0 for 101 ms -> 6 rising edges spaced 500_000 clocks apart, each high 25_000 clocks. Total sim time is 101 ms at 40 ns clock.
- Steady `sw`=1 -> the first frame is 25_000 high (reset width). Every later frame is 50_000 high, period 500_000.
- Toggle `sw` 0→1 at 5 ms (mid-frame) -> frame 0 stays 25_000 high and frame 1 is 50_000 high. Toggle 1→0 at 29 ms -> frame 2 is 25_000 high.
- Toggle `sw` 1 clock before the load cycle -> the change misses the latch and applies one frame later. Toggle ≥3 clocks before -> it applies to the next frame.
- Assert `rst` asynchronously mid-pulse at 20.5 ms -> `salida` goes 0 without waiting for a clock edge. After release the frame restarts from `cnt`=0 with a 25_000-clock pulse.
